// File: rtl/triangle.sv
// Pipelined point-in-triangle classifier: 11-bit unsigned coordinates, three register stages.
// Build option: TRIANGLE_EDGE_INCLUSIVE_EN counts points on an edge or vertex as inside.
module triangle (
    input  logic        CLK,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [10:0] PointX,
    input  logic [10:0] PointY,
    input  logic [10:0] X_1,
    input  logic [10:0] Y_1,
    input  logic [10:0] X_2,
    input  logic [10:0] Y_2,
    input  logic [10:0] X_3,
    input  logic [10:0] Y_3,
    output logic        out_valid,
    output logic        Exit,
    output logic        Degenerate
);

    logic [10:0]        vx [3];
    logic [10:0]        vy [3];

    logic signed [11:0] ex_d [3], ey_d [3], px_d [3], py_d [3];
    logic signed [11:0] ex_q [3], ey_q [3], px_q [3], py_q [3];
    logic               v1_q;

    logic signed [23:0] pa_d [3], pb_d [3];
    logic signed [23:0] pa_q [3], pb_q [3];
    logic               v2_q;

    logic signed [24:0] c [3];
    logic signed [26:0] area;
    logic [2:0]         c_neg, c_pos;
    logic               same_side;
    logic               exit_d, degen_d;
    logic               out_valid_q, exit_q, degen_q;

    assign vx[0] = X_1;
    assign vx[1] = X_2;
    assign vx[2] = X_3;
    assign vy[0] = Y_1;
    assign vy[1] = Y_2;
    assign vy[2] = Y_3;

    // Edge i runs from vertex i to vertex (i+1) mod 3.
    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int J = (i + 1) % 3;

        assign ex_d[i] = {1'b0, vx[J]} - {1'b0, vx[i]};
        assign ey_d[i] = {1'b0, vy[J]} - {1'b0, vy[i]};
        assign px_d[i] = {1'b0, PointX} - {1'b0, vx[i]};
        assign py_d[i] = {1'b0, PointY} - {1'b0, vy[i]};

        // Low 24 bits of the sign-extended product are the exact signed product.
        assign pa_d[i] = $signed({{12{ex_q[i][11]}}, ex_q[i]} * {{12{py_q[i][11]}}, py_q[i]});
        assign pb_d[i] = $signed({{12{ey_q[i][11]}}, ey_q[i]} * {{12{px_q[i][11]}}, px_q[i]});

        assign c[i]     = {pa_q[i][23], pa_q[i]} - {pb_q[i][23], pb_q[i]};
        assign c_neg[i] = c[i][24];
        assign c_pos[i] = ~c[i][24] & (c[i] != '0);
    end

    assign area = {{2{c[0][24]}}, c[0]} + {{2{c[1][24]}}, c[1]} + {{2{c[2][24]}}, c[2]};

    always_comb begin
        degen_d   = (area == '0);
`ifdef TRIANGLE_EDGE_INCLUSIVE_EN
        same_side = (c_neg == 3'b000) | (c_pos == 3'b000);
`else
        same_side = (c_pos == 3'b111) | (c_neg == 3'b111);
`endif
        exit_d    = same_side & ~degen_d;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            exit_q      <= 1'b0;
            degen_q     <= 1'b0;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (in_valid) begin
                ex_q <= ex_d;
                ey_q <= ey_d;
                px_q <= px_d;
                py_q <= py_d;
            end
            if (v1_q) begin
                pa_q <= pa_d;
                pb_q <= pb_d;
            end
            // Results hold between valid queries.
            if (v2_q) begin
                exit_q  <= exit_d;
                degen_q <= degen_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign Exit       = exit_q;
    assign Degenerate = degen_q;

endmodule

// File: tb/tb_triangle.sv
// Self-checking bench for triangle: directed plan vectors plus randomized queries against a shoelace/edge model.
module tb_triangle;

    logic        CLK = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [10:0] PointX, PointY, X_1, Y_1, X_2, Y_2, X_3, Y_3;
    logic        out_valid, Exit, Degenerate;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit last_ex, last_dg;

`ifdef TRIANGLE_EDGE_INCLUSIVE_EN
    localparam bit ON_EDGE_EXIT = 1'b1;
`else
    localparam bit ON_EDGE_EXIT = 1'b0;
`endif

    always #5 CLK = ~CLK;

    triangle dut (
        .CLK        (CLK),
        .rst        (rst),
        .in_valid   (in_valid),
        .PointX     (PointX),
        .PointY     (PointY),
        .X_1        (X_1),
        .Y_1        (Y_1),
        .X_2        (X_2),
        .Y_2        (Y_2),
        .X_3        (X_3),
        .Y_3        (Y_3),
        .out_valid  (out_valid),
        .Exit       (Exit),
        .Degenerate (Degenerate)
    );

    // Reference: shoelace area for degeneracy, per-edge cross products for side tests.
    function automatic void model(input int px, input int py, input int x1, input int y1,
                                  input int x2, input int y2, input int x3, input int y3,
                                  output bit ex, output bit dg);
        int xs[3];
        int ys[3];
        int cv, area, npos, nneg;
        xs = '{x1, x2, x3};
        ys = '{y1, y2, y3};
        area = (x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1);
        npos = 0;
        nneg = 0;
        for (int i = 0; i < 3; i++) begin
            int j;
            j  = (i + 1) % 3;
            cv = (xs[j] - xs[i]) * (py - ys[i]) - (ys[j] - ys[i]) * (px - xs[i]);
            if (cv > 0) npos++;
            if (cv < 0) nneg++;
        end
        dg = (area == 0);
`ifdef TRIANGLE_EDGE_INCLUSIVE_EN
        ex = !dg && (npos == 0 || nneg == 0);
`else
        ex = !dg && (npos == 3 || nneg == 3);
`endif
    endfunction

    task automatic drive(input int px, input int py, input int x1, input int y1,
                         input int x2, input int y2, input int x3, input int y3, input logic v);
        PointX = 11'(px); PointY = 11'(py);
        X_1 = 11'(x1); Y_1 = 11'(y1);
        X_2 = 11'(x2); Y_2 = 11'(y2);
        X_3 = 11'(x3); Y_3 = 11'(y3);
        in_valid = v;
    endtask

    task automatic drive_idle();
        drive($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            drive($urandom_range(0, 2047), $urandom_range(0, 2047), 0, 0, 100, 0, 0, 100, 1'b1);
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL reset_valid k=%0d: got %b expected 0", k, out_valid);
            else pass_cnt++;
        end
        total_cnt++;
        if (Exit !== 1'b0 || Degenerate !== 1'b0)
            $display("FAIL reset_outputs: got Exit=%b Degenerate=%b expected 0/0", Exit, Degenerate);
        else pass_cnt++;
        @(negedge CLK);
        rst = 1'b0;
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL reset_release_valid k=%0d: got %b expected 0", k, out_valid);
            else pass_cnt++;
        end
        last_ex = 1'b0;
        last_dg = 1'b0;
    endtask

    task automatic test_directed();
        int tv[9][8];
        bit te[9];
        bit td[9];
        //        px  py  x1  y1  x2  y2  x3  y3
        tv[0] = '{ 3,  3,  0,  0, 10,  0,  0, 10};
        tv[1] = '{ 3,  3, 15, 15, 30,  0, 15,  0};
        tv[2] = '{ 3,  3, 15,  0, 30,  0, 15, 15};
        tv[3] = '{20,  5, 15,  0, 30,  0, 15, 15};
        tv[4] = '{20,  5, 15, 15, 30,  0, 15,  0};
        tv[5] = '{ 5,  0,  0,  0, 10,  0,  0, 10};
        tv[6] = '{ 0,  0,  0,  0, 10,  0,  0, 10};
        tv[7] = '{ 5,  5,  0,  0,  5,  5, 10, 10};
        tv[8] = '{ 3,  3,  0,  0, 10,  0,  0, 10};
        te = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ON_EDGE_EXIT, ON_EDGE_EXIT, 1'b0, 1'b1};
        td = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 9; n++) begin
            @(negedge CLK);
            drive(tv[n][0], tv[n][1], tv[n][2], tv[n][3], tv[n][4], tv[n][5], tv[n][6], tv[n][7], 1'b1);
            @(negedge CLK);
            drive_idle();
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL directed_early_valid n=%0d: got %b expected 0", n, out_valid);
            else pass_cnt++;
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || Exit !== te[n] || Degenerate !== td[n])
                $display("FAIL directed n=%0d: got valid=%b Exit=%b Degenerate=%b expected 1/%b/%b",
                         n, out_valid, Exit, Degenerate, te[n], td[n]);
            else pass_cnt++;
            last_ex = te[n];
            last_dg = td[n];
        end
    endtask

    task automatic test_back_to_back();
        int pts[3][2];
        bit eb[3];
        bit exp_v;
        pts = '{'{1, 1}, '{2047, 2047}, '{1023, 1023}};
        eb  = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 3) drive(pts[k][0], pts[k][1], 0, 0, 2047, 0, 0, 2047, 1'b1);
            else drive_idle();
            @(posedge CLK); #1;
            exp_v = (k >= 2 && k <= 4);
            total_cnt++;
            if (out_valid !== exp_v) $display("FAIL b2b_valid k=%0d: got %b expected %b", k, out_valid, exp_v);
            else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (Exit !== eb[k-2] || Degenerate !== 1'b0)
                    $display("FAIL b2b_result k=%0d: got Exit=%b Degenerate=%b expected %b/0",
                             k, Exit, Degenerate, eb[k-2]);
                else pass_cnt++;
            end
        end
        last_ex = 1'b1;
        last_dg = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 300;
        bit ev[N+2];
        bit ee[N+2];
        bit ed[N+2];
        int c[8];
        bit e, d, v;
        for (int k = 0; k < N + 2; k++) begin
            ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = 1'b0;
        end
        for (int k = 0; k < N + 2; k++) begin
            @(negedge CLK);
            if (k < N) begin
                v = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 3))
                    0: for (int m = 0; m < 8; m++) c[m] = $urandom_range(0, 2047);
                    1: begin
                        int bx, by;
                        bx = $urandom_range(0, 1900);
                        by = $urandom_range(0, 1900);
                        for (int m = 0; m < 8; m += 2) begin
                            c[m]   = bx + $urandom_range(0, 147);
                            c[m+1] = by + $urandom_range(0, 147);
                        end
                    end
                    2: begin
                        int dx, dy;
                        c[2] = $urandom_range(0, 1000); c[3] = $urandom_range(0, 1000);
                        dx = $urandom_range(0, 500);    dy = $urandom_range(0, 500);
                        c[4] = c[2] + dx;     c[5] = c[3] + dy;
                        c[6] = c[2] + 2 * dx; c[7] = c[3] + 2 * dy;
                        c[0] = c[4];          c[1] = c[5] + $urandom_range(0, 1);
                    end
                    default: begin
                        for (int m = 2; m < 8; m++) c[m] = 2 * $urandom_range(0, 1023);
                        c[0] = (c[2] + c[4]) / 2;
                        c[1] = (c[3] + c[5]) / 2;
                    end
                endcase
                drive(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], v);
                if (v) begin
                    model(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], e, d);
                    ev[k+2] = 1'b1; ee[k+2] = e; ed[k+2] = d;
                end
            end else begin
                drive_idle();
            end
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== ev[k]) $display("FAIL rand_valid k=%0d: got %b expected %b", k, out_valid, ev[k]);
            else pass_cnt++;
            if (ev[k]) begin
                total_cnt++;
                if (Exit !== ee[k] || Degenerate !== ed[k])
                    $display("FAIL rand_result k=%0d: got Exit=%b Degenerate=%b expected %b/%b",
                             k, Exit, Degenerate, ee[k], ed[k]);
                else pass_cnt++;
                last_ex = ee[k];
                last_dg = ed[k];
            end else begin
                total_cnt++;
                if (Exit !== last_ex || Degenerate !== last_dg)
                    $display("FAIL rand_hold k=%0d: got Exit=%b Degenerate=%b expected %b/%b",
                             k, Exit, Degenerate, last_ex, last_dg);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_flush();
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k < 2) drive(3, 3, 0, 0, 10, 0, 0, 10, 1'b1);
            else drive_idle();
            rst = (k == 2);
            @(posedge CLK); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL flush_valid k=%0d: got %b expected 0", k, out_valid);
            else pass_cnt++;
            if (k >= 2) begin
                total_cnt++;
                if (Exit !== 1'b0 || Degenerate !== 1'b0)
                    $display("FAIL flush_outputs k=%0d: got Exit=%b Degenerate=%b expected 0/0",
                             k, Exit, Degenerate);
                else pass_cnt++;
            end
        end
        @(negedge CLK);
        drive(3, 3, 0, 0, 10, 0, 0, 10, 1'b1);
        @(negedge CLK);
        drive_idle();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || Exit !== 1'b1 || Degenerate !== 1'b0)
            $display("FAIL flush_recover: got valid=%b Exit=%b Degenerate=%b expected 1/1/0",
                     out_valid, Exit, Degenerate);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
